calc_seq_ctrl: RTL and testbench
================================

# calc_seq_ctrl

Program sequencer for the 8-bit calculator core. It holds a small program of (opcode, operand) steps and issues each step to the core using the core's operand/opcode/strobe protocol. After each step it captures the core's result and flags, and it can stop early on a flag condition. It sits between the chip's external load/start pins and the calculator core, and is the only master driving the core's strobe.

## Interface
Parameters:
- DEPTH, 8: program entries (power of two, 2..16)
- SETTLE_CYCLES, 2: cycles after the strobe pulse before result/flags are sampled (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- ena  in  1  design enabled; start is accepted only when high
- load_valid  in  1  write program entry this cycle
- load_addr  in  $clog2(DEPTH)  entry index
- load_entry  in  16  {last, mask[2:0], op[3:0], operand[7:0]}
- start  in  1  begin program at entry 0
- abort  in  1  cancel a running program
- core_operand  out  8  operand to core
- core_op  out  4  opcode to core
- core_strobe  out  1  one-cycle execute pulse to core
- core_result  in  8  core accumulator
- core_flags  in  3  core flags
- result  out  8  last captured core_result
- flags  out  3  last captured core_flags
- steps  out  5  steps completed in current/last run
- busy  out  1  program running
- done  out  1  one-cycle pulse at normal or early completion
- early_stop  out  1  last run ended on a flag match; held until next start

## Operation
- Opcodes follow the core encoding: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 LSL, 6 LSR, 7 ASR, 8 NEG, 9 INV, A REV, D LT, E GT, F EQU. 0xB and 0xC are passed through unchecked.
- FSM states: IDLE, SETUP, PULSE, SETTLE, DONE.
- IDLE:
  - load_valid writes mem[load_addr].
  - start && ena → SETUP. Sets pc=0, steps=0, early_stop=0.
- SETUP (1 cycle): core_op/core_operand load from mem[pc]; core_strobe=0.
- PULSE (1 cycle): core_strobe=1; op/operand held.
- SETTLE (SETTLE_CYCLES cycles): core_strobe=0; op/operand held.
  - On the last cycle: result←core_result, flags←core_flags, steps←steps+1.
- Next-step decision, using the captured flags:
  - (core_flags & mask) != 0 → DONE with early_stop=1.
  - Otherwise, last==1 or pc==DEPTH-1 → DONE.
  - Otherwise pc++ → SETUP.
- DONE (1 cycle): done=1, busy=0 → IDLE.
- busy=1 in SETUP, PULSE and SETTLE.
- Boundary and conflict rules:
  - load_valid while busy: ignored, memory unchanged.
  - start while busy or in DONE: ignored.
  - load_valid and start in the same IDLE cycle: the write completes; SETUP reads the new data when load_addr==0.
  - abort while busy has priority over every transition. Next state is IDLE, core_strobe=0 next cycle, no done pulse, result/flags/steps keep their last captured values.
  - abort while IDLE: no effect.
  - Reset at any point: state=IDLE; all outputs 0 (result, flags, steps, core_*, busy, done, early_stop). Program memory is not reset and is undefined until written.

## Timing
- All outputs are registered.
- Per step: 2+SETTLE_CYCLES cycles, 4 at default.
- Start sampled at edge t0 → first core_strobe high during cycle t0+2.
- N-step program, default parameters: done high during cycle t0+4N+1.
- core_strobe is never high two consecutive cycles; at least SETTLE_CYCLES+1 low cycles between pulses.

## Structure
- Package calc_pkg:
  - opcode_t enum of the codes above
  - prog_entry_t packed struct {last, mask, op, operand}
  - seq_state_t enum
  - ENTRY_W=16
- Sub-module calc_prog_mem: DEPTH×16 register file, one synchronous write port and one asynchronous read port, no reset.
- Top: FSM, pc, settle counter, capture registers.

## Test plan
- Reset, then a core model with accumulator 0. Load [ADD 0xFF], [SUB 0x0F last]; start.
  - core_strobe pulses at t0+2 and t0+6.
  - result=0xFF after step 1, 0xF0 after step 2.
  - done at t0+9, steps=2, early_stop=0.
- Program of 8 entries with no last bit: runs all DEPTH entries.
  - done at t0+33, steps=8, pc wrap never occurs.
- Entry 1 mask=3'b001; core model returns flags=3'b001 on step 2; 4-entry program.
  - done after step 2, steps=2, early_stop=1, flags=3'b001.
- abort asserted in step 2's PULSE cycle.
  - IDLE next cycle, core_strobe=0, no done.
  - result keeps step-1 value, steps=1, busy=0.
- load_valid to entry 0 (OR 0x01) and start in the same cycle: first issued core_op=2, core_operand=0x01.
- start and load_valid asserted while busy: ignored.
  - Program completes unchanged.
  - Memory readback on a later run shows the original entries.
- start with ena=0: no transition.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the calculator program sequencer: opcodes, program entry layout, FSM states.
package calc_pkg;

   localparam int unsigned ENTRY_W = 16;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned FLAG_W  = 3;
   localparam int unsigned STEPS_W = 5;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 4'h0,
      OP_SUB = 4'h1,
      OP_OR  = 4'h2,
      OP_AND = 4'h3,
      OP_XOR = 4'h4,
      OP_LSL = 4'h5,
      OP_LSR = 4'h6,
      OP_ASR = 4'h7,
      OP_NEG = 4'h8,
      OP_INV = 4'h9,
      OP_REV = 4'hA,
      OP_LT  = 4'hD,
      OP_GT  = 4'hE,
      OP_EQU = 4'hF
   } opcode_t;

   // op stays a raw code so the unnamed 0xB/0xC values pass through to the core untouched
   typedef struct packed {
      logic              last;
      logic [FLAG_W-1:0] mask;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] operand;
   } prog_entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_SETTLE,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/calc_prog_mem.sv
// Program store: DEPTH x ENTRY_W register file, synchronous write, asynchronous read, no reset.
module calc_prog_mem
   import calc_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  prog_entry_t              wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output prog_entry_t              rdata_c_o
);

   prog_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/calc_seq_ctrl.sv
// Program sequencer for the 8-bit calculator core: issues stored (op, operand) steps,
// captures result/flags after a settle window, and stops on last entry or a flag match.
module calc_seq_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     load_valid,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [ENTRY_W-1:0]       load_entry,
   input  logic                     start,
   input  logic                     abort,
   output logic [DATA_W-1:0]        core_operand,
   output logic [OP_W-1:0]          core_op,
   output logic                     core_strobe,
   input  logic [DATA_W-1:0]        core_result,
   input  logic [FLAG_W-1:0]        core_flags,
   output logic [DATA_W-1:0]        result,
   output logic [FLAG_W-1:0]        flags,
   output logic [STEPS_W-1:0]       steps,
   output logic                     busy,
   output logic                     done,
   output logic                     early_stop
);

   localparam int unsigned PC_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   seq_state_t         state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OP_W-1:0]    op_q, op_d;
   logic [DATA_W-1:0]  operand_q, operand_d;
   logic               strobe_q, strobe_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic [FLAG_W-1:0]  flags_q, flags_d;
   logic [STEPS_W-1:0] steps_q, steps_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               early_q, early_d;

   logic               mem_we_c;
   prog_entry_t        rd_entry_c;

   calc_prog_mem #(
      .DEPTH (DEPTH)
   ) u_prog_mem (
      .clk       (clk),
      .we_i      (mem_we_c),
      .waddr_i   (load_addr),
      .wdata_i   (prog_entry_t'(load_entry)),
      .raddr_i   (pc_q),
      .rdata_c_o (rd_entry_c)
   );

   // Next-state and registered-output decode
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      operand_d = operand_q;
      result_d  = result_q;
      flags_d   = flags_q;
      steps_d   = steps_q;
      early_d   = early_q;
      mem_we_c  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            mem_we_c = load_valid;
            if (start && ena) begin
               state_d = S_SETUP;
               pc_d    = '0;
               steps_d = '0;
               early_d = 1'b0;
            end
         end
         S_SETUP: begin
            op_d      = rd_entry_c.op;
            operand_d = rd_entry_c.operand;
            state_d   = S_PULSE;
         end
         S_PULSE: begin
            cnt_d   = '0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               result_d = core_result;
               flags_d  = core_flags;
               steps_d  = steps_q + STEPS_W'(1);
               if ((core_flags & rd_entry_c.mask) != '0) begin
                  early_d = 1'b1;
                  state_d = S_DONE;
               end else if (rd_entry_c.last || (pc_q == PC_W'(DEPTH - 1))) begin
                  state_d = S_DONE;
               end else begin
                  pc_d    = pc_q + PC_W'(1);
                  state_d = S_SETUP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // abort wins over every transition and discards any capture in flight
      if (abort && busy_q) begin
         state_d  = S_IDLE;
         pc_d     = pc_q;
         result_d = result_q;
         flags_d  = flags_q;
         steps_d  = steps_q;
         early_d  = early_q;
      end

      strobe_d = (state_d == S_PULSE);
      busy_d   = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_SETTLE);
      done_d   = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
         operand_q <= '0;
         strobe_q  <= 1'b0;
         result_q  <= '0;
         flags_q   <= '0;
         steps_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         early_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         strobe_q  <= strobe_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
         steps_q   <= steps_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         early_q   <= early_d;
      end
   end

   assign core_op      = op_q;
   assign core_operand = operand_q;
   assign core_strobe  = strobe_q;
   assign result       = result_q;
   assign flags        = flags_q;
   assign steps        = steps_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign early_stop   = early_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: behavioural calculator core plus a
// program-level reference that predicts issue timing, captures and completion.
module tb_calc_seq_ctrl;

   localparam int DEPTH  = 8;
   localparam int SETTLE = 2;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic        load_valid;
   logic [2:0]  load_addr;
   logic [15:0] load_entry;
   logic        start;
   logic        abort;
   logic [7:0]  core_operand;
   logic [3:0]  core_op;
   logic        core_strobe;
   logic [7:0]  core_result;
   logic [2:0]  core_flags;
   logic [7:0]  result;
   logic [2:0]  flags;
   logic [4:0]  steps;
   logic        busy;
   logic        done;
   logic        early_stop;

   int          errors;
   int          checks;

   logic [15:0] prog     [0:DEPTH-1];
   logic [2:0]  flag_tab [0:15];
   logic        core_clr;
   int          nstep;

   calc_seq_ctrl #(
      .DEPTH         (DEPTH),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .load_valid   (load_valid),
      .load_addr    (load_addr),
      .load_entry   (load_entry),
      .start        (start),
      .abort        (abort),
      .core_operand (core_operand),
      .core_op      (core_op),
      .core_strobe  (core_strobe),
      .core_result  (core_result),
      .core_flags   (core_flags),
      .result       (result),
      .flags        (flags),
      .steps        (steps),
      .busy         (busy),
      .done         (done),
      .early_stop   (early_stop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] alu(input logic [7:0] a, input logic [3:0] op, input logic [7:0] b);
      logic [7:0] r;
      case (op)
         4'h0: r = a + b;
         4'h1: r = a - b;
         4'h2: r = a | b;
         4'h3: r = a & b;
         4'h4: r = a ^ b;
         4'h5: r = a << b[2:0];
         4'h6: r = a >> b[2:0];
         4'h7: r = $signed(a) >>> b[2:0];
         4'h8: r = 8'd0 - a;
         4'h9: r = ~a;
         4'hA: for (int j = 0; j < 8; j++) r[j] = a[7-j];
         4'hD: r = (a < b) ? 8'd1 : 8'd0;
         4'hE: r = (a > b) ? 8'd1 : 8'd0;
         4'hF: r = (a == b) ? 8'd1 : 8'd0;
         default: r = a ^ b;
      endcase
      return r;
   endfunction

   // Calculator core: accumulator updates on each strobe, flags come from a per-step table
   always @(posedge clk) begin
      if (core_clr) begin
         core_result <= 8'd0;
         core_flags  <= 3'd0;
         nstep       <= 0;
      end else if (core_strobe) begin
         core_result <= alu(core_result, core_op, core_operand);
         core_flags  <= flag_tab[nstep];
         nstep       <= nstep + 1;
      end
   end

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_addr  = 3'(i);
         load_entry = prog[i];
      end
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   // Runs the stored program once; abort_at>0 raises abort during that cycle offset
   task automatic run_prog(input int abort_at, input bit poke_busy, input bit ld_start,
                           input logic [15:0] ld_entry);
      logic [7:0] acc;
      logic [7:0] res_at [0:15];
      logic [2:0] flg_exp;
      bit         early_exp;
      bit         got_done;
      bit         seen;
      int         n;
      int         sidx;
      int         cap;
      int         s;

      if (ld_start) prog[0] = ld_entry;
      acc = 8'd0; n = 0; early_exp = 1'b0; flg_exp = 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
         acc       = alu(acc, prog[i][11:8], prog[i][7:0]);
         res_at[i] = acc;
         flg_exp   = flag_tab[i];
         n         = i + 1;
         if ((flag_tab[i] & prog[i][14:12]) != 3'd0) begin
            early_exp = 1'b1;
            break;
         end
         if (prog[i][15]) break;
      end

      @(negedge clk);
      core_clr = 1'b1;
      @(negedge clk);
      core_clr = 1'b0;
      start    = 1'b1;
      if (ld_start) begin
         load_valid = 1'b1;
         load_addr  = 3'd0;
         load_entry = ld_entry;
      end
      @(posedge clk);
      sidx = 0; got_done = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start      = 1'b0;
            load_valid = 1'b0;
            check_eq("busy_after_start", busy, 1);
         end
         if (core_strobe) begin
            if (sidx < n) begin
               check_eq("strobe_time", k, 2 + 4 * sidx);
               check_eq("issue_op", core_op, prog[sidx][11:8]);
               check_eq("issue_operand", core_operand, prog[sidx][7:0]);
            end
            sidx++;
         end
         cap = (k - 5) / 4;
         if (k >= 5 && (k - 5) % 4 == 0 && cap < n && (abort_at == 0 || k <= abort_at)) begin
            check_eq("step_result", result, res_at[cap]);
            check_eq("step_count", steps, cap + 1);
         end
         if (abort_at > 0 && k == abort_at + 1) begin
            abort = 1'b0;
            s = (abort_at >= 5) ? ((abort_at - 5) / 4 + 1) : 0;
            if (s > n) s = n;
            check_eq("abort_busy", busy, 0);
            check_eq("abort_strobe", core_strobe, 0);
            check_eq("abort_steps", steps, s);
            if (s > 0) check_eq("abort_result", result, res_at[s-1]);
            seen = 1'b0;
            for (int j = 0; j < 8; j++) begin
               @(negedge clk);
               if (done || busy || core_strobe) seen = 1'b1;
            end
            check_eq("abort_quiet", seen, 0);
            return;
         end
         if (abort_at > 0 && k == abort_at) abort = 1'b1;
         if (poke_busy && k == 3) begin
            start      = 1'b1;
            load_valid = 1'b1;
            load_addr  = 3'd0;
            load_entry = 16'($urandom);
         end
         if (poke_busy && k == 4) begin
            start      = 1'b0;
            load_valid = 1'b0;
         end
         if (done) begin
            got_done = 1'b1;
            check_eq("done_time", k, 4 * n + 1);
            check_eq("done_result", result, res_at[n-1]);
            check_eq("done_flags", flags, flg_exp);
            check_eq("done_steps", steps, n);
            check_eq("done_early", early_stop, early_exp);
            check_eq("done_busy", busy, 0);
            check_eq("strobe_count", sidx, n);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_eq("start_in_done", busy, 0);
            check_eq("early_held", early_stop, early_exp);
            break;
         end
      end
      if (!got_done) check_eq("done_timeout", 0, 1);
   endtask

   task automatic rand_prog(input bit allow_stop);
      for (int i = 0; i < DEPTH; i++) begin
         prog[i][7:0]   = 8'($urandom);
         prog[i][11:8]  = 4'($urandom);
         prog[i][14:12] = (allow_stop && $urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
         prog[i][15]    = allow_stop && ($urandom_range(0, 4) == 0);
      end
      for (int i = 0; i < 16; i++) flag_tab[i] = 3'($urandom);
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0; ena = 1'b1; load_valid = 1'b0; load_addr = 3'd0; load_entry = 16'd0;
      start = 1'b0; abort = 1'b0; core_clr = 1'b1;
      for (int i = 0; i < 16; i++) flag_tab[i] = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_outputs", {core_operand, core_op, core_strobe, result, flags, steps, busy, done, early_stop}, 0);
      rst_n = 1'b1;

      // two-step ADD/SUB program
      prog[0] = 16'h00FF;
      prog[1] = 16'h810F;
      for (int i = 2; i < DEPTH; i++) prog[i] = 16'h0000;
      load_prog();
      run_prog(0, 1'b0, 1'b0, 16'h0);

      // full-depth program without last bits
      rand_prog(1'b0);
      load_prog();
      run_prog(0, 1'b0, 1'b0, 16'h0);

      // early stop on entry 1 flag match
      rand_prog(1'b0);
      for (int i = 0; i < 16; i++) flag_tab[i] = 3'd0;
      flag_tab[0] = 3'b110;
      flag_tab[1] = 3'b001;
      prog[1][14:12] = 3'b001;
      prog[3][15]    = 1'b1;
      load_prog();
      run_prog(0, 1'b0, 1'b0, 16'h0);

      // abort during step 2 PULSE
      rand_prog(1'b0);
      load_prog();
      run_prog(6, 1'b0, 1'b0, 16'h0);

      // load entry 0 together with start
      run_prog(0, 1'b0, 1'b1, 16'h0201);

      // start/load while busy are ignored; next run reads the original entries
      run_prog(0, 1'b1, 1'b0, 16'h0);
      run_prog(0, 1'b0, 1'b0, 16'h0);

      // start with ena low
      @(negedge clk);
      ena = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("ena_low_busy", busy, 0);
      repeat (3) @(negedge clk);
      check_eq("ena_low_idle", {busy, done, core_strobe}, 0);
      ena = 1'b1;

      // randomized programs and flag patterns
      for (int r = 0; r < 8; r++) begin
         rand_prog(1'b1);
         load_prog();
         run_prog(0, r[0], 1'b0, 16'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
